// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin sharing of one pipelined CORDIC unit between two requesters
//
// cordic_arbiter: two requesters issue sin/cos or vector-rotate operations to a
// single pipelined CORDIC unit. A tag pipeline of LAT stages follows every
// issued operation so its result can be steered into the owner's result FIFO.
// Per-requester credits (ops in flight + FIFO entries) never exceed DEPTH, so a
// result always finds room in its FIFO.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   reqK_valid/ready             request handshake for requester K (0/1)
//   reqK_mode                    0 = sin/cos of angle, 1 = rotate (x,y) by angle
//   reqK_angle/x/y               request payload, Q3.29
//   c_trig_rot, c_angle,
//   c_xi, c_yi                   registered inputs to the CORDIC unit
//   c_xr, c_yr                   CORDIC outputs
//   resK_valid/ready             result FIFO K head valid / pop
//   resK_x, resK_y               result FIFO K head (cos/sin in trig mode)
//   busy                         an op is in flight or a result is queued
//
// cordic_res_fifo: small power-of-two result queue with extra-bit pointers.
//   clk, rst                     clock, synchronous active-high reset
//   wr_en, wr_data               push
//   rd_en                        pop (ignored when empty)
//   rd_data, valid               head entry, non-empty flag

module cordic_res_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         valid
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // The extra pointer bit distinguishes full from empty; equal pointers mean empty.
  assign valid   = (wr_ptr != rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && valid)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

module cordic_arbiter #(
  parameter int           N     = 32,
  parameter int           LAT   = 10,
  parameter int           DEPTH = 4,
  parameter logic [N-1:0] KINIT = 32'h136E9DB5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_mode,
  input  logic [N-1:0] req0_angle,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_mode,
  input  logic [N-1:0] req1_angle,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  output logic         c_trig_rot,
  output logic [N-1:0] c_angle,
  output logic [N-1:0] c_xi,
  output logic [N-1:0] c_yi,
  input  logic [N-1:0] c_xr,
  input  logic [N-1:0] c_yr,
  output logic         res0_valid,
  input  logic         res0_ready,
  output logic [N-1:0] res0_x,
  output logic [N-1:0] res0_y,
  output logic         res1_valid,
  input  logic         res1_ready,
  output logic [N-1:0] res1_x,
  output logic [N-1:0] res1_y,
  output logic         busy
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]  cred0, cred1;
  logic           elig0, elig1;
  logic           grant0, grant1;
  logic           rr_last;        // 1: requester 1 was granted last, so requester 0 wins a tie
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_id;
  logic           wr0, wr1;
  logic           pop0, pop1;
  logic           sel_mode;
  logic [N-1:0]   sel_angle, sel_x, sel_y;
  logic [2*N-1:0] fifo0_data, fifo1_data;

  assign elig0 = req0_valid && (cred0 < DEPTH_C);
  assign elig1 = req1_valid && (cred1 < DEPTH_C);

  // Each grant depends only on eligibility, never on the other port's ready.
  assign grant0 = elig0 && (!elig1 || rr_last);
  assign grant1 = elig1 && (!elig0 || !rr_last);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_mode  = grant1 ? req1_mode  : req0_mode;
  assign sel_angle = grant1 ? req1_angle : req0_angle;
  assign sel_x     = grant1 ? req1_x     : req0_x;
  assign sel_y     = grant1 ? req1_y     : req0_y;

  always_ff @(posedge clk) begin
    if (rst)
      rr_last <= 1'b1;
    else if (grant0)
      rr_last <= 1'b0;
    else if (grant1)
      rr_last <= 1'b1;
  end

  // CORDIC input registers hold the last issued operation while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_trig_rot <= 1'b0;
      c_angle    <= '0;
      c_xi       <= '0;
      c_yi       <= '0;
    end else if (grant0 || grant1) begin
      c_trig_rot <= sel_mode;
      c_angle    <= sel_angle;
      c_xi       <= sel_mode ? sel_x : KINIT;
      c_yi       <= sel_mode ? sel_y : '0;
    end
  end

  // Tag stage 0 is loaded on the issue edge; the last stage lines up with c_xr/c_yr.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[LAT-2:0], grant0 || grant1};
      tag_id <= {tag_id[LAT-2:0], grant1};
    end
  end

  assign wr0  = tag_v[LAT-1] && !tag_id[LAT-1];
  assign wr1  = tag_v[LAT-1] &&  tag_id[LAT-1];
  assign pop0 = res0_valid && res0_ready;
  assign pop1 = res1_valid && res1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cred0 <= '0;
      cred1 <= '0;
    end else begin
      case ({grant0, pop0})
        2'b10:   cred0 <= cred0 + CW'(1);
        2'b01:   cred0 <= cred0 - CW'(1);
        default: cred0 <= cred0;
      endcase
      case ({grant1, pop1})
        2'b10:   cred1 <= cred1 + CW'(1);
        2'b01:   cred1 <= cred1 - CW'(1);
        default: cred1 <= cred1;
      endcase
    end
  end

  cordic_res_fifo #(.W(2*N), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr0),
    .wr_data ({c_xr, c_yr}),
    .rd_en   (res0_ready),
    .rd_data (fifo0_data),
    .valid   (res0_valid)
  );

  cordic_res_fifo #(.W(2*N), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr1),
    .wr_data ({c_xr, c_yr}),
    .rd_en   (res1_ready),
    .rd_data (fifo1_data),
    .valid   (res1_valid)
  );

  assign res0_x = fifo0_data[2*N-1:N];
  assign res0_y = fifo0_data[N-1:0];
  assign res1_x = fifo1_data[2*N-1:N];
  assign res1_y = fifo1_data[N-1:0];

  assign busy = (|tag_v) || res0_valid || res1_valid;
endmodule
